// File: rtl/subway_sensor_cond.sv
// Two-channel trackside photo-sensor conditioner: synchroniser, debouncer, stuck-beam watch.
// Stuck-beam fault detection is built only when SUBWAY_SENSOR_FAULT_DET_EN is defined.

module subway_sensor_cond #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8,
    parameter int STUCK_CYCLES    = 1000,
    parameter int STUCK_W         = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_p1,
    input  logic       raw_p2,
    input  logic       fault_clr,
    output logic       p1,
    output logic       p2,
    output logic [1:0] fault
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]            s1_q, s2_q;
    logic [1:0]            db_q, db_d;
    logic [1:0]            p_q, p_d;
    logic [1:0]            fault_st;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q  <= '0;
            s2_q  <= '0;
            db_q  <= '0;
            cnt_q <= '0;
            p_q   <= '0;
        end else begin
            s1_q  <= {raw_p2, raw_p1};
            s2_q  <= s1_q;
            db_q  <= db_d;
            cnt_q <= cnt_d;
            p_q   <= p_d;
        end
    end

    // Counter restarts whenever the synchronised level agrees with the debounced one.
    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q;
        for (int ch = 0; ch < 2; ch++) begin
            if (s2_q[ch] == db_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_LAST) begin
                db_d[ch]  = s2_q[ch];
                cnt_d[ch] = '0;
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
        end
    end

`ifdef SUBWAY_SENSOR_FAULT_DET_EN
    localparam logic [STUCK_W-1:0] ST_MAX = STUCK_W'(STUCK_CYCLES);

    logic [1:0][STUCK_W-1:0] st_q, st_d;
    logic [1:0]              fault_q, fault_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q    <= '0;
            fault_q <= '0;
        end else begin
            st_q    <= st_d;
            fault_q <= fault_d;
        end
    end

    // Clear beats a coincident set; the timer restarts so a re-set needs a full period.
    always_comb begin
        st_d    = st_q;
        fault_d = fault_q;
        for (int ch = 0; ch < 2; ch++) begin
            if (fault_clr) begin
                st_d[ch]    = '0;
                fault_d[ch] = 1'b0;
            end else begin
                if (!db_q[ch]) begin
                    st_d[ch] = '0;
                end else if (st_q[ch] != ST_MAX) begin
                    st_d[ch] = st_q[ch] + STUCK_W'(1);
                end
                if (st_q[ch] == ST_MAX) begin
                    fault_d[ch] = 1'b1;
                end
            end
        end
    end

    assign fault_st = fault_q;
`else
    logic unused_cfg;
    assign unused_cfg = fault_clr ^ (STUCK_CYCLES > 0) ^ (STUCK_W > 0);
    assign fault_st   = 2'b00;
`endif

    assign p_d   = db_q & ~fault_st;
    assign p1    = p_q[0];
    assign p2    = p_q[1];
    assign fault = fault_st;

endmodule
